// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU DMA engine: command enums, FSM state
// encoding and the element-count to byte-count conversion.
package tpu_pkg;

    localparam int DMA_LEN_W = 16;   // element count width
    localparam int DMA_CNT_W = 18;   // byte count width (length << elem_sz)

    typedef enum logic {
        DMA_H2T = 1'b0,
        DMA_T2H = 1'b1
    } dma_dir_e;

    typedef enum logic [1:0] {
        ELEM_8    = 2'd0,
        ELEM_16   = 2'd1,
        ELEM_32   = 2'd2,
        ELEM_RSVD = 2'd3
    } dma_elem_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        H2T     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        TX      = 3'd4,
        DONE    = 3'd5
    } dma_state_e;

    // Total bytes moved by a command. The reserved size never moves data,
    // so its result is don't-care.
    function automatic logic [DMA_CNT_W-1:0] dma_byte_total(
        input logic [DMA_LEN_W-1:0] len,
        input logic [1:0]           sz
    );
        logic [DMA_CNT_W-1:0] ext;
        ext = {{(DMA_CNT_W-DMA_LEN_W){1'b0}}, len};
        return ext << sz;
    endfunction

endpackage

// File: rtl/tpu_dma_engine_packer.sv
// Host->TPU byte packer: tracks the current lane, accumulates bytes into a
// word little-endian and produces the word / byte enables to write when the
// word fills up or the command's last byte arrives.
module tpu_dma_packer
    import tpu_pkg::*;
#(
    parameter int UB_BYTES = 4,
    localparam int LANE_W  = $clog2(UB_BYTES),
    localparam int DATA_W  = 8 * UB_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,   // new command: drop any partial word
    input  logic              push_i,    // a host byte is accepted this cycle
    input  logic [7:0]        data_i,
    input  logic              last_i,    // the pushed byte is the command's final byte
    output logic              flush_o,   // word must be written next cycle
    output logic [DATA_W-1:0] word_o,    // pack register with the incoming byte merged
    output logic [UB_BYTES-1:0] be_o     // lanes 0..current filled
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] pack_q, pack_d;

    // Merge the incoming byte into its lane and decide whether the word is complete.
    always_comb begin
        word_o = pack_q;
        be_o   = '0;
        for (int k = 0; k < UB_BYTES; k++) begin
            if (k == int'(lane_q)) word_o[8*k +: 8] = data_i;
            if (k <= int'(lane_q)) be_o[k] = 1'b1;
        end
        flush_o = push_i && ((lane_q == LANE_W'(UB_BYTES-1)) || last_i);

        pack_d = pack_q;
        lane_d = lane_q;
        if (clear_i) begin
            pack_d = '0;
            lane_d = '0;
        end else if (push_i) begin
            if (flush_o) begin
                // The word leaves via the write port, so the register frees up at once.
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = word_o;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    // Pack register and lane counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            lane_q <= '0;
        end else begin
            pack_q <= pack_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/tpu_dma_engine.sv
// DMA engine between the host byte stream and the Unified Buffer. H2T packs
// incoming bytes into UB words; T2H reads UB words and serialises them into
// bytes. All outputs are registered.
//
// Handshakes: a byte moves on a rising edge where valid and ready are both
// high. A sender keeps valid and data stable until that edge; valid never
// waits on ready.
module tpu_dma_engine
    import tpu_pkg::*;
#(
    parameter int UB_ADDR_W = 8,
    parameter int UB_BYTES  = 4,
    localparam int LANE_W   = $clog2(UB_BYTES),
    localparam int DATA_W   = 8 * UB_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // command interface
    input  logic                 dma_start,
    input  logic                 dma_dir,
    input  logic [UB_ADDR_W-1:0] dma_ub_addr,
    input  logic [15:0]          dma_length,
    input  logic [1:0]           dma_elem_sz,
    output logic                 dma_busy,
    output logic                 dma_done,
    output logic                 dma_err,
    // host -> TPU
    input  logic [7:0]           h_rx_data,
    input  logic                 h_rx_valid,
    output logic                 h_rx_ready,
    // TPU -> host
    output logic [7:0]           h_tx_data,
    output logic                 h_tx_valid,
    input  logic                 h_tx_ready,
    // Unified Buffer write port
    output logic                 ub_wr_en,
    output logic [UB_ADDR_W-1:0] ub_wr_addr,
    output logic [DATA_W-1:0]    ub_wr_data,
    output logic [UB_BYTES-1:0]  ub_wr_be,
    // Unified Buffer read port (data one cycle after ub_rd_en)
    output logic                 ub_rd_en,
    output logic [UB_ADDR_W-1:0] ub_rd_addr,
    input  logic [DATA_W-1:0]    ub_rd_data,
    // debug view of the FSM
    output logic [2:0]           dbg_state_o
);

    dma_state_e             state_q;
    logic [DMA_CNT_W-1:0]   n_q;        // bytes in the command
    logic [DMA_CNT_W-1:0]   cnt_q;      // bytes already moved
    logic [UB_ADDR_W-1:0]   addr_q;     // next UB word address
    logic                   busy_q, done_q, err_q;
    logic                   rx_ready_q;
    logic [7:0]             tx_data_q;
    logic                   tx_valid_q;
    logic [DATA_W-1:0]      hold_q;     // UB word being serialised
    logic                   wr_en_q;
    logic [UB_ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic [UB_BYTES-1:0]    wr_be_q;
    logic                   rd_en_q;
    logic [UB_ADDR_W-1:0]   rd_addr_q;

    logic [DMA_CNT_W-1:0]   n_cmd;
    logic                   accept;
    logic                   rx_fire;
    logic                   tx_fire;
    logic                   last_byte;
    logic [LANE_W-1:0]      tx_lane;
    logic [LANE_W-1:0]      tx_lane_nx;
    logic                   word_end;
    logic [7:0]             tx_next_byte;

    logic                   pk_flush;
    logic [DATA_W-1:0]      pk_word;
    logic [UB_BYTES-1:0]    pk_be;

    // Handshake qualifiers, byte position and the next byte to present in T2H.
    always_comb begin
        n_cmd      = dma_byte_total(dma_length, dma_elem_sz);
        accept     = (state_q == IDLE) && dma_start;
        rx_fire    = (state_q == H2T) && h_rx_valid && rx_ready_q;
        tx_fire    = (state_q == TX) && tx_valid_q && h_tx_ready;
        last_byte  = (cnt_q == (n_q - DMA_CNT_W'(1)));
        tx_lane    = cnt_q[LANE_W-1:0];
        tx_lane_nx = tx_lane + LANE_W'(1);
        word_end   = (tx_lane == LANE_W'(UB_BYTES-1));
        tx_next_byte = '0;
        for (int k = 0; k < UB_BYTES; k++) begin
            if (LANE_W'(k) == tx_lane_nx) tx_next_byte = hold_q[8*k +: 8];
        end
    end

    tpu_dma_packer #(
        .UB_BYTES (UB_BYTES)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept),
        .push_i  (rx_fire),
        .data_i  (h_rx_data),
        .last_i  (last_byte),
        .flush_o (pk_flush),
        .word_o  (pk_word),
        .be_o    (pk_be)
    );

    // Command FSM with all host / UB outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            hold_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dma_start) begin
                        n_q    <= n_cmd;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        err_q  <= (dma_elem_sz == ELEM_RSVD);
                        if ((dma_elem_sz == ELEM_RSVD) || (n_cmd == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (dma_dir == DMA_H2T) begin
                            state_q    <= H2T;
                            rx_ready_q <= 1'b1;
                            addr_q     <= dma_ub_addr;
                        end else begin
                            state_q   <= RD_REQ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= dma_ub_addr;
                            addr_q    <= dma_ub_addr + UB_ADDR_W'(1);
                        end
                    end
                end
                H2T: begin
                    if (rx_fire) begin
                        cnt_q <= cnt_q + DMA_CNT_W'(1);
                        if (last_byte) rx_ready_q <= 1'b0;
                    end
                    if (pk_flush) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= pk_word;
                        wr_be_q   <= pk_be;
                        addr_q    <= addr_q + UB_ADDR_W'(1);
                    end
                    // Ready low here means the final word is on the write port now.
                    if (!rx_ready_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    hold_q     <= ub_rd_data;
                    tx_data_q  <= ub_rd_data[7:0];
                    tx_valid_q <= 1'b1;
                    state_q    <= TX;
                end
                TX: begin
                    if (tx_fire) begin
                        cnt_q <= cnt_q + DMA_CNT_W'(1);
                        if (last_byte) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                        end else if (word_end) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= RD_REQ;
                            rd_en_q    <= 1'b1;
                            rd_addr_q  <= addr_q;
                            addr_q     <= addr_q + UB_ADDR_W'(1);
                        end else begin
                            tx_data_q <= tx_next_byte;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dma_busy    = busy_q;
    assign dma_done    = done_q;
    assign dma_err     = err_q;
    assign h_rx_ready  = rx_ready_q;
    assign h_tx_data   = tx_data_q;
    assign h_tx_valid  = tx_valid_q;
    assign ub_wr_en    = wr_en_q;
    assign ub_wr_addr  = wr_addr_q;
    assign ub_wr_data  = wr_data_q;
    assign ub_wr_be    = wr_be_q;
    assign ub_rd_en    = rd_en_q;
    assign ub_rd_addr  = rd_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tpu_dma_engine.sv
// Bench for tpu_dma_engine: directed scenarios plus randomized commands,
// checked against expected UB writes and host bytes computed from the
// command fields and a UB memory model.
module tb_tpu_dma_engine;

    localparam int AW = 8;
    localparam int NB = 4;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          dma_start = 1'b0;
    logic          dma_dir = 1'b0;
    logic [AW-1:0] dma_ub_addr = '0;
    logic [15:0]   dma_length = '0;
    logic [1:0]    dma_elem_sz = '0;
    logic          dma_busy, dma_done, dma_err;
    logic [7:0]    h_rx_data = '0;
    logic          h_rx_valid = 1'b0;
    logic          h_rx_ready;
    logic [7:0]    h_tx_data;
    logic          h_tx_valid;
    logic          h_tx_ready = 1'b0;
    logic          ub_wr_en;
    logic [AW-1:0] ub_wr_addr;
    logic [DW-1:0] ub_wr_data;
    logic [NB-1:0] ub_wr_be;
    logic          ub_rd_en;
    logic [AW-1:0] ub_rd_addr;
    logic [DW-1:0] ub_rd_data = '0;
    logic [2:0]    dbg_state_o;

    tpu_dma_engine #(.UB_ADDR_W(AW), .UB_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_ub_addr(dma_ub_addr),
        .dma_length(dma_length), .dma_elem_sz(dma_elem_sz),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
        .h_rx_data(h_rx_data), .h_rx_valid(h_rx_valid), .h_rx_ready(h_rx_ready),
        .h_tx_data(h_tx_data), .h_tx_valid(h_tx_valid), .h_tx_ready(h_tx_ready),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data), .ub_wr_be(ub_wr_be),
        .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
        .dbg_state_o(dbg_state_o)
    );

    // reference state: UB contents, host bytes, expected queues
    logic [DW-1:0] mem [256];
    logic [7:0]    hb [$];
    logic [AW-1:0] exp_wa_q [$];
    logic [DW-1:0] exp_wd_q [$];
    logic [NB-1:0] exp_be_q [$];
    logic [7:0]    exp_tx_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard comparison
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},     32'(dma_busy), 0);
        check_eq({tag, "_done"},     32'(dma_done), 0);
        check_eq({tag, "_err"},      32'(dma_err), 0);
        check_eq({tag, "_rx_ready"}, 32'(h_rx_ready), 0);
        check_eq({tag, "_tx_valid"}, 32'(h_tx_valid), 0);
        check_eq({tag, "_tx_data"},  32'(h_tx_data), 0);
        check_eq({tag, "_wr_en"},    32'(ub_wr_en), 0);
        check_eq({tag, "_wr_addr"},  32'(ub_wr_addr), 0);
        check_eq({tag, "_wr_data"},  ub_wr_data, 0);
        check_eq({tag, "_wr_be"},    32'(ub_wr_be), 0);
        check_eq({tag, "_rd_en"},    32'(ub_rd_en), 0);
        check_eq({tag, "_rd_addr"},  32'(ub_rd_addr), 0);
    endtask

    // driver: issue one command, play host and UB sides, score everything
    task automatic run_cmd(input logic dir, input logic [7:0] base, input logic [15:0] len,
                           input logic [1:0] sz, input int stall, input bit fixed,
                           input bit poke, input bit chk_cyc);
        int n, nwords, sent, extra, rd_cnt, done_cnt, busy_cyc, cyc;
        bit seen_done, rd_prev;
        logic [DW-1:0] w;
        logic [NB-1:0] be;
        n = (sz == 2'd3) ? 0 : (int'(len) << sz);
        nwords = (n + NB - 1) / NB;
        hb.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_be_q.delete(); exp_tx_q.delete();
        for (int i = 0; i < n; i++) hb.push_back(fixed ? 8'(i + 1) : 8'($urandom));
        if (dir == 1'b0) begin
            for (int wi = 0; wi < nwords; wi++) begin
                w = '0; be = '0;
                for (int k = 0; k < NB; k++) begin
                    if (wi * NB + k < n) begin
                        w[8*k +: 8] = hb[wi * NB + k];
                        be[k] = 1'b1;
                    end
                end
                exp_wa_q.push_back(8'(int'(base) + wi));
                exp_wd_q.push_back(w);
                exp_be_q.push_back(be);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                w = mem[8'(int'(base) + i / NB)];
                exp_tx_q.push_back(w[8*(i % NB) +: 8]);
            end
        end
        sent = 0; extra = 0; rd_cnt = 0; done_cnt = 0; busy_cyc = 0; cyc = 0;
        seen_done = 1'b0; rd_prev = 1'b0;

        @(negedge clk);
        dma_start = 1'b1; dma_dir = dir; dma_ub_addr = base; dma_length = len; dma_elem_sz = sz;
        h_rx_valid = 1'b0; h_tx_ready = 1'b0;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            dma_start = 1'b0;
            if (poke && cyc == 3) begin
                dma_start   = 1'b1;
                dma_dir     = 1'($urandom);
                dma_ub_addr = 8'($urandom);
                dma_length  = 16'($urandom_range(1, 9));
                dma_elem_sz = 2'($urandom);
            end
            if (dma_busy) busy_cyc++;
            if (dma_done) begin done_cnt++; seen_done = 1'b1; end
            // UB read model: data appears the cycle after the strobe
            if (ub_rd_en) begin
                rd_cnt++;
                ub_rd_data = mem[ub_rd_addr];
            end else if (!rd_prev) begin
                ub_rd_data = DW'($urandom);
            end
            rd_prev = ub_rd_en;
            if (ub_wr_en) begin
                if (exp_wa_q.size() == 0) check_eq("wr_unexpected", 1, 0);
                else begin
                    check_eq("wr_addr", 32'(ub_wr_addr), 32'(exp_wa_q.pop_front()));
                    check_eq("wr_data", ub_wr_data, exp_wd_q.pop_front());
                    check_eq("wr_be", 32'(ub_wr_be), 32'(exp_be_q.pop_front()));
                end
            end
            // host transmitter: junk stays offered after the last byte
            if (dir == 1'b0 && sent < n) begin
                h_rx_valid = ($urandom_range(0, 99) >= stall);
                h_rx_data  = hb[sent];
            end else begin
                h_rx_valid = 1'b1;
                h_rx_data  = 8'hEE;
            end
            if (h_rx_valid && h_rx_ready) begin
                if (dir == 1'b0 && sent < n) sent++;
                else extra++;
            end
            // host receiver
            h_tx_ready = ($urandom_range(0, 99) >= stall);
            if (h_tx_valid && h_tx_ready) begin
                if (exp_tx_q.size() == 0) check_eq("tx_extra", 1, 0);
                else check_eq("tx_byte", 32'(h_tx_data), 32'(exp_tx_q.pop_front()));
            end
        end
        dma_start = 1'b0; h_rx_valid = 1'b0; h_tx_ready = 1'b0;
        check_eq("done_seen", 32'(seen_done), 1);
        @(negedge clk);
        check_eq("busy_after", 32'(dma_busy), 0);
        check_eq("done_width", 32'(dma_done), 0);
        check_eq("done_cnt", done_cnt, 1);
        check_eq("rd_cnt", rd_cnt, dir ? nwords : 0);
        check_eq("wr_left", exp_wa_q.size(), 0);
        check_eq("tx_left", exp_tx_q.size(), 0);
        check_eq("rx_sent", sent, dir ? 0 : n);
        check_eq("rx_extra", extra, 0);
        check_eq("err", 32'(dma_err), 32'(sz == 2'd3));
        if (chk_cyc) check_eq("busy_cycles", busy_cyc, (n == 0) ? 1 : n + 2);
    endtask

    initial begin
        int acc, guard, wr_seen;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);

        // reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 8 bytes, full throughput
        run_cmd(1'b0, 8'h10, 16'd8, 2'd0, 0, 1'b1, 1'b0, 1'b1);
        // 16-bit elements, partial word cases
        run_cmd(1'b0, 8'h30, 16'd3, 2'd1, 30, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 8'h34, 16'd5, 2'd0, 0, 1'b0, 1'b0, 1'b1);
        // T2H with partial final word and host backpressure
        mem[8'h20] = 32'hA3A2A1A0;
        mem[8'h21] = 32'hB3B2B1B0;
        run_cmd(1'b1, 8'h20, 16'd6, 2'd0, 40, 1'b0, 1'b0, 1'b0);
        // address wrap
        run_cmd(1'b0, 8'hFF, 16'd8, 2'd0, 20, 1'b1, 1'b0, 1'b0);
        run_cmd(1'b1, 8'hFF, 16'd3, 2'd2, 20, 1'b0, 1'b0, 1'b0);
        // zero length and reserved element size
        run_cmd(1'b0, 8'h50, 16'd0, 2'd0, 0, 1'b0, 1'b0, 1'b1);
        run_cmd(1'b1, 8'h50, 16'd7, 2'd3, 0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("err_sticky", 32'(dma_err), 1);
        run_cmd(1'b1, 8'h60, 16'd2, 2'd2, 25, 1'b0, 1'b0, 1'b0);
        // start while busy is ignored
        run_cmd(1'b0, 8'h70, 16'd12, 2'd0, 10, 1'b0, 1'b1, 1'b0);
        run_cmd(1'b1, 8'h80, 16'd4, 2'd1, 10, 1'b0, 1'b1, 1'b0);

        // reset in the middle of an H2T command
        @(negedge clk);
        dma_start = 1'b1; dma_dir = 1'b0; dma_ub_addr = 8'h40; dma_length = 16'd8; dma_elem_sz = 2'd0;
        @(negedge clk);
        dma_start = 1'b0;
        acc = 0; guard = 0; wr_seen = 0;
        while (acc < 2 && guard < 50) begin
            h_rx_valid = 1'b1;
            h_rx_data  = 8'(8'hC0 + acc);
            if (h_rx_ready) acc++;
            @(negedge clk);
            guard++;
            if (ub_wr_en) wr_seen++;
        end
        check_eq("rst_rx_acc", acc, 2);
        h_rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        if (ub_wr_en) wr_seen++;
        check_eq("midrst_no_write", wr_seen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(1'b0, 8'h40, 16'd4, 2'd0, 0, 1'b1, 1'b0, 1'b1);

        // randomized commands
        for (int t = 0; t < 14; t++) begin
            logic       r_dir;
            logic [1:0] r_sz;
            r_dir = 1'($urandom_range(0, 1));
            r_sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_cmd(r_dir, 8'($urandom), 16'($urandom_range(0, 12)), r_sz,
                    $urandom_range(0, 60), 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
